// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants shared by the timing generator, pixel painter and game logic.
// Counter values are 10-bit unsigned throughout.
package vga_timing_pkg;

    typedef logic [9:0] cnt_t;

    localparam int CNT_W       = 10;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;

    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 515;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clk_en.sv
// Pixel-rate clock enable: a free-running 0..CLK_DIV-1 counter whose last count
// marks the system-clock edge on which the raster counters advance.
module pixel_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so pix_en stays high.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical pixel counters stepped by the pixel enable,
// with sync, visible-window and once-per-frame tick decoded combinationally from them.
module vga_timing_gen
    import vga_timing_pkg::cnt_t;
    import vga_timing_pkg::in_window;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input  logic       clk,
    input  logic       Reset,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    cnt_t h_q;
    cnt_t h_d;
    cnt_t v_q;
    cnt_t v_d;
    logic line_end;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .clk    (clk),
        .Reset  (Reset),
        .pix_en (pix_en)
    );

    assign line_end = pix_en && (h_q == H_LAST);

    // Line wrap and the vertical step share one edge, so both come from the same decode.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + cnt_t'(1);
        end
        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = !(h_q < cnt_t'(H_SYNC));
    assign vSync      = !(v_q < cnt_t'(V_SYNC));
    assign bright     = in_window(h_q, cnt_t'(H_VIS_START), cnt_t'(H_VIS_END)) &&
                        in_window(v_q, cnt_t'(V_VIS_START), cnt_t'(V_VIS_END));
    assign frame_tick = line_end && (v_q == V_LAST);

endmodule
